// File: rtl/cd_pkg.sv
// Shared types and default widths for the compression/decompression initiator.
package cd_pkg;

  localparam int CD_DATA_W  = 80;
  localparam int CD_COMP_W  = 8;
  localparam int CD_TIMEOUT = 16;

  typedef enum logic [1:0] {
    CMD_NOP        = 2'b00,
    CMD_COMPRESS   = 2'b01,
    CMD_DECOMPRESS = 2'b10,
    CMD_RSVD       = 2'b11
  } cd_cmd_e;

  typedef enum logic [1:0] {
    RSP_NONE        = 2'b00,
    RSP_COMP_DONE   = 2'b01,
    RSP_DECOMP_DONE = 2'b10,
    RSP_ERR         = 2'b11
  } cd_rsp_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_HOLD  = 2'b11
  } cd_init_state_e;

endpackage

// File: rtl/cd_timeout_counter.sv
// Response-wait counter; expired flags the enabled cycle in which the count reaches TIMEOUT.
module cd_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TC = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count_q, count_d, count_inc;

  assign count_inc = count_q + CNT_W'(1);
  assign expired   = enable && (count_inc == TC);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != TC)) begin
      count_d = count_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/cd_initiator.sv
// One-outstanding-job requester for the compression/decompression command interface.
// Optional counters: define CD_INITIATOR_STATS_EN to add stat_issued/stat_errors/stat_spurious.
//
// state    | meaning
// ST_IDLE  | ready for a job
// ST_ISSUE | command driven to the engine for one cycle
// ST_WAIT  | polling response, timeout counter running
// ST_HOLD  | result presented until rsp_ready
module cd_initiator
  import cd_pkg::*;
#(
  parameter int DATA_W  = CD_DATA_W,
  parameter int COMP_W  = CD_COMP_W,
  parameter int TIMEOUT = CD_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_cmd,
  input  logic [DATA_W-1:0] req_data,
  input  logic [COMP_W-1:0] req_comp,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_code,
  output logic              rsp_timeout,
  output logic [COMP_W-1:0] rsp_comp,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        command,
  output logic [DATA_W-1:0] data_in,
  output logic [COMP_W-1:0] compressed_in,
  input  logic [COMP_W-1:0] compressed_out,
  input  logic [DATA_W-1:0] decompressed_out,
  input  logic [1:0]        response
`ifdef CD_INITIATOR_STATS_EN
  ,
  output logic [15:0]       stat_issued,
  output logic [15:0]       stat_errors,
  output logic [15:0]       stat_spurious
`endif
);

  cd_init_state_e    state_q, state_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [COMP_W-1:0] comp_q, comp_d;
  logic [1:0]        rsp_code_q, rsp_code_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [COMP_W-1:0] rsp_comp_q, rsp_comp_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              expired;

  cd_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q == ST_ISSUE),
    .enable  ((state_q == ST_WAIT) && (response == RSP_NONE)),
    .expired (expired)
  );

  assign req_ready     = (state_q == ST_IDLE);
  assign rsp_valid     = (state_q == ST_HOLD);
  assign command       = (state_q == ST_ISSUE) ? cmd_q : CMD_NOP;
  assign data_in       = data_q;
  assign compressed_in = comp_q;
  assign rsp_code      = rsp_code_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign rsp_comp      = rsp_comp_q;
  assign rsp_data      = rsp_data_q;

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    data_d        = data_q;
    comp_d        = comp_q;
    rsp_code_d    = rsp_code_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_comp_d    = rsp_comp_q;
    rsp_data_d    = rsp_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          data_d = req_data;
          comp_d = req_comp;
          if ((req_cmd == CMD_COMPRESS) || (req_cmd == CMD_DECOMPRESS)) begin
            cmd_d   = req_cmd;
            state_d = ST_ISSUE;
          end else begin
            // Illegal job is answered locally; the engine never sees it.
            rsp_code_d    = RSP_ERR;
            rsp_timeout_d = 1'b0;
            state_d       = ST_HOLD;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (response != RSP_NONE) begin
          rsp_code_d    = response;
          rsp_timeout_d = 1'b0;
          rsp_comp_d    = compressed_out;
          rsp_data_d    = decompressed_out;
          state_d       = ST_HOLD;
        end else if (expired) begin
          rsp_code_d    = RSP_ERR;
          rsp_timeout_d = 1'b1;
          state_d       = ST_HOLD;
        end
      end
      ST_HOLD: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cmd_q         <= CMD_NOP;
      data_q        <= '0;
      comp_q        <= '0;
      rsp_code_q    <= RSP_NONE;
      rsp_timeout_q <= 1'b0;
      rsp_comp_q    <= '0;
      rsp_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      data_q        <= data_d;
      comp_q        <= comp_d;
      rsp_code_q    <= rsp_code_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_comp_q    <= rsp_comp_d;
      rsp_data_q    <= rsp_data_d;
    end
  end

`ifdef CD_INITIATOR_STATS_EN
  logic [15:0] stat_issued_q, stat_issued_d;
  logic [15:0] stat_errors_q, stat_errors_d;
  logic [15:0] stat_spurious_q, stat_spurious_d;

  always_comb begin
    stat_issued_d   = stat_issued_q;
    stat_errors_d   = stat_errors_q;
    stat_spurious_d = stat_spurious_q;
    if ((state_q == ST_ISSUE) && (stat_issued_q != 16'hFFFF))
      stat_issued_d = stat_issued_q + 16'd1;
    if ((state_d == ST_HOLD) && (state_q != ST_HOLD) && (rsp_code_d == RSP_ERR)
        && (stat_errors_q != 16'hFFFF))
      stat_errors_d = stat_errors_q + 16'd1;
    if ((response != RSP_NONE) && ((state_q == ST_IDLE) || (state_q == ST_HOLD))
        && (stat_spurious_q != 16'hFFFF))
      stat_spurious_d = stat_spurious_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_issued_q   <= '0;
      stat_errors_q   <= '0;
      stat_spurious_q <= '0;
    end else begin
      stat_issued_q   <= stat_issued_d;
      stat_errors_q   <= stat_errors_d;
      stat_spurious_q <= stat_spurious_d;
    end
  end

  assign stat_issued   = stat_issued_q;
  assign stat_errors   = stat_errors_q;
  assign stat_spurious = stat_spurious_q;
`endif

endmodule

// File: tb/tb_cd_initiator.sv
// Directed bench for cd_initiator with TIMEOUT=4; the engine side is driven by hand.
module tb_cd_initiator;

  localparam int DATA_W = 80;
  localparam int COMP_W = 8;
  localparam logic [79:0] VAL_D = 80'h0035_0000_0026_0000_0025;
  localparam logic [79:0] VAL_E = 80'h1111_2222_3333_4444_5555;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_cmd;
  logic [DATA_W-1:0] req_data;
  logic [COMP_W-1:0] req_comp;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_code;
  logic              rsp_timeout;
  logic [COMP_W-1:0] rsp_comp;
  logic [DATA_W-1:0] rsp_data;
  logic [1:0]        command;
  logic [DATA_W-1:0] data_in;
  logic [COMP_W-1:0] compressed_in;
  logic [COMP_W-1:0] compressed_out;
  logic [DATA_W-1:0] decompressed_out;
  logic [1:0]        response;

  int n_chk = 0;
  int n_err = 0;

  cd_initiator #(.DATA_W(DATA_W), .COMP_W(COMP_W), .TIMEOUT(4)) u_dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_cmd          (req_cmd),
    .req_data         (req_data),
    .req_comp         (req_comp),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_code         (rsp_code),
    .rsp_timeout      (rsp_timeout),
    .rsp_comp         (rsp_comp),
    .rsp_data         (rsp_data),
    .command          (command),
    .data_in          (data_in),
    .compressed_in    (compressed_in),
    .compressed_out   (compressed_out),
    .decompressed_out (decompressed_out),
    .response         (response)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_req_ready"}, req_ready, 1'b1);
    check_val({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check_val({tag, "_command"}, command, 2'b00);
    check_val({tag, "_data_in"}, data_in, '0);
    check_val({tag, "_comp_in"}, compressed_in, '0);
    check_val({tag, "_rsp_code"}, rsp_code, 2'b00);
    check_val({tag, "_rsp_timeout"}, rsp_timeout, 1'b0);
    check_val({tag, "_rsp_comp"}, rsp_comp, '0);
    check_val({tag, "_rsp_data"}, rsp_data, '0);
  endtask

  task automatic offer(input logic [1:0] cmd, input logic [79:0] data, input logic [7:0] comp);
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_data  = data;
    req_comp  = comp;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_cmd = 2'b00; req_data = '0; req_comp = '0;
    rsp_ready = 1'b0; response = 2'b00; compressed_out = '0; decompressed_out = '0;
    step(); step();
    reset = 1'b0;
    step();
    check_reset_outputs("reset");

    // Compress: engine answers in the second WAIT cycle.
    offer(2'b01, VAL_D, 8'h00);
    step();
    req_valid = 1'b0;
    check_val("comp_cmd_issue", command, 2'b01);
    check_val("comp_req_ready_issue", req_ready, 1'b0);
    check_val("comp_data_in", data_in, VAL_D);
    step();
    check_val("comp_cmd_wait1", command, 2'b00);
    check_val("comp_no_valid_wait1", rsp_valid, 1'b0);
    step();
    response = 2'b01; compressed_out = 8'hF0;
    step();
    response = 2'b00;
    check_val("comp_rsp_valid", rsp_valid, 1'b1);
    check_val("comp_rsp_code", rsp_code, 2'b01);
    check_val("comp_rsp_comp", rsp_comp, 8'hF0);
    check_val("comp_rsp_timeout", rsp_timeout, 1'b0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check_val("comp_back_idle_valid", rsp_valid, 1'b0);
    check_val("comp_back_idle_ready", req_ready, 1'b1);

    // Decompress: engine answers in the first WAIT cycle, minimum latency.
    offer(2'b10, VAL_E, 8'hF0);
    step();
    req_valid = 1'b0;
    check_val("decomp_cmd_issue", command, 2'b10);
    check_val("decomp_comp_in", compressed_in, 8'hF0);
    response = 2'b11;
    step();
    response = 2'b10; decompressed_out = VAL_D; compressed_out = 8'h5A;
    check_val("decomp_issue_rsp_ignored", rsp_valid, 1'b0);
    step();
    response = 2'b00;
    check_val("decomp_rsp_valid", rsp_valid, 1'b1);
    check_val("decomp_rsp_code", rsp_code, 2'b10);
    check_val("decomp_rsp_data", rsp_data, VAL_D);
    check_val("decomp_rsp_comp", rsp_comp, 8'h5A);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    decompressed_out = '0; compressed_out = '0;

    // Timeout: accept at N, rsp_valid at N+6 with TIMEOUT=4.
    offer(2'b01, VAL_E, 8'h00);
    step();
    req_valid = 1'b0;
    check_val("to_cmd_issue", command, 2'b01);
    for (int i = 2; i <= 5; i++) begin
      step();
      check_val($sformatf("to_cmd_n%0d", i), command, 2'b00);
      check_val($sformatf("to_no_valid_n%0d", i), rsp_valid, 1'b0);
    end
    step();
    check_val("to_rsp_valid", rsp_valid, 1'b1);
    check_val("to_rsp_code", rsp_code, 2'b11);
    check_val("to_rsp_timeout", rsp_timeout, 1'b1);
    check_val("to_rsp_comp_kept", rsp_comp, 8'h5A);
    check_val("to_rsp_data_kept", rsp_data, VAL_D);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Illegal command: answered next cycle, engine never commanded.
    offer(2'b11, VAL_E, 8'h77);
    check_val("ill_cmd_idle", command, 2'b00);
    step();
    req_valid = 1'b0;
    check_val("ill_rsp_valid", rsp_valid, 1'b1);
    check_val("ill_rsp_code", rsp_code, 2'b11);
    check_val("ill_rsp_timeout", rsp_timeout, 1'b0);
    check_val("ill_cmd_hold", command, 2'b00);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check_val("ill_cmd_after", command, 2'b00);

    // Backpressure, then a second job accepted right after the handshake.
    offer(2'b01, VAL_D, 8'h00);
    step();
    req_valid = 1'b0;
    step();
    response = 2'b01; compressed_out = 8'h3C;
    step();
    for (int i = 0; i < 5; i++) begin
      response = (i % 2 == 0) ? 2'b10 : 2'b00;
      compressed_out = 8'(8'hA0 + i);
      check_val($sformatf("bp_valid_%0d", i), rsp_valid, 1'b1);
      check_val($sformatf("bp_code_%0d", i), rsp_code, 2'b01);
      check_val($sformatf("bp_comp_%0d", i), rsp_comp, 8'h3C);
      check_val($sformatf("bp_req_ready_%0d", i), req_ready, 1'b0);
      step();
    end
    response = 2'b00;
    check_val("bp_still_valid", rsp_valid, 1'b1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check_val("b2b_req_ready", req_ready, 1'b1);
    offer(2'b10, VAL_E, 8'h42);
    step();
    req_valid = 1'b0;
    check_val("b2b_cmd_issue", command, 2'b10);
    check_val("b2b_comp_in", compressed_in, 8'h42);

    // Reset during WAIT drops the job.
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    response = 2'b01;
    check_reset_outputs("rst_wait");
    step();
    response = 2'b00;
    check_val("rst_no_valid", rsp_valid, 1'b0);
    step();
    check_val("rst_no_valid2", rsp_valid, 1'b0);

    // Job after reset completes normally.
    offer(2'b10, VAL_E, 8'h99);
    step();
    req_valid = 1'b0;
    check_val("post_rst_cmd", command, 2'b10);
    step();
    response = 2'b10; decompressed_out = VAL_E; compressed_out = 8'h11;
    step();
    response = 2'b00;
    check_val("post_rst_valid", rsp_valid, 1'b1);
    check_val("post_rst_code", rsp_code, 2'b10);
    check_val("post_rst_data", rsp_data, VAL_E);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check_val("post_rst_idle", req_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
